atm_txn_arbiter: RTL

- Owns the shared account balance store.
- Serialises balance, withdraw and deposit transactions from N_TERM ATM terminal front-ends.
- Uses a round-robin grant and a fixed read/execute/write sequence, so concurrent terminals never interleave read-modify-write on any account.
- Sits between the per-terminal session FSMs, which have already authenticated the account, and the balance storage.

---
 rtl/atm_txn_arbiter_if.sv | 25 ++
 rtl/atm_txn_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/atm_txn_arbiter_if.sv
// Terminal-side bus for atm_txn_arbiter. The terminals (master) drive requests,
// and the arbiter (slave) returns grants, completions and results.
interface atm_txn_arbiter_if #(
    parameter int N_TERM = 4
);
    logic [N_TERM-1:0]    req;
    logic [2*N_TERM-1:0]  op;
    logic [4*N_TERM-1:0]  acc_num;
    logic [32*N_TERM-1:0] amount;
    logic [N_TERM-1:0]    gnt;
    logic [N_TERM-1:0]    done;
    logic                 rsp_success;
    logic [31:0]          rsp_balance;
    logic                 busy;

    modport master (
        output req, op, acc_num, amount,
        input  gnt, done, rsp_success, rsp_balance, busy
    );

    modport slave (
        input  req, op, acc_num, amount,
        output gnt, done, rsp_success, rsp_balance, busy
    );
endinterface

// File: rtl/atm_txn_arbiter.sv
// atm_txn_arbiter: owns the account balance store and serialises balance,
// withdraw and deposit transactions from N_TERM terminals using a round-robin
// grant and a fixed read/execute/write sequence.
// Optional macro ATM_DAILY_LIMIT_EN adds per-account daily withdraw totals
// that are checked against DAILY_LIMIT and cleared by day_clear.
//
// state   | meaning
// IDLE    | waiting for a request; captures the round-robin winner
// READ    | validates the account index and fetches its balance
// EXEC    | evaluates the operation and computes the new balance
// WRITE   | commits the new balance and raises done/response
// DONE    | done pulse visible; grant released, pointer advanced
module atm_txn_arbiter #(
    parameter int N_TERM      = 4,
    parameter int NUM_ACC     = 10,
    parameter int DAILY_LIMIT = 5000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             day_clear,
    atm_txn_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(N_TERM);
    localparam logic [1:0] OP_BAL = 2'b00;
    localparam logic [1:0] OP_WD  = 2'b01;
    localparam logic [1:0] OP_DEP = 2'b10;

    typedef enum logic [2:0] {S_IDLE, S_READ, S_EXEC, S_WRITE, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]    win_q, win_d;
    logic [1:0]          op_q, op_d;
    logic [3:0]          acc_q, acc_d;
    logic [31:0]         amt_q, amt_d;
    logic [31:0]         bal_q, bal_d;
    logic [31:0]         new_q, new_d;
    logic                succ_q, succ_d;
    logic [N_TERM-1:0]   gnt_q, gnt_d;
    logic [N_TERM-1:0]   done_q, done_d;
    logic                rsp_success_q, rsp_success_d;
    logic [31:0]         rsp_balance_q, rsp_balance_d;
    logic                busy_q, busy_d;
    logic [31:0]         store_q [NUM_ACC];
    logic [31:0]         store_d [NUM_ACC];

    logic                pick_found;
    logic [IDX_W-1:0]    pick_idx;
    logic [IDX_W-1:0]    cand;
    logic [1:0]          pick_op;
    logic [3:0]          pick_acc;
    logic [31:0]         pick_amt;
    logic                acc_ok;
    logic [31:0]         rd_bal;
    logic [32:0]         sum33;
    logic                limit_ok;

`ifdef ATM_DAILY_LIMIT_EN
    logic [31:0]         today_q [NUM_ACC];
    logic [31:0]         today_d [NUM_ACC];
    logic [31:0]         rd_today;
`else
    logic                unused_cfg;
    assign unused_cfg = day_clear ^ (DAILY_LIMIT != 0);
`endif

    // Round-robin winner: first set req bit above rr_ptr, wrapping, plus its operands.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        pick_op    = '0;
        pick_acc   = '0;
        pick_amt   = '0;
        for (int k = 1; k <= N_TERM; k++) begin
            cand = IDX_W'((int'(rr_ptr_q) + k) % N_TERM);
            if (!pick_found && bus.req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
        for (int j = 0; j < N_TERM; j++) begin
            if (IDX_W'(j) == pick_idx) begin
                pick_op  = bus.op[2*j +: 2];
                pick_acc = bus.acc_num[4*j +: 4];
                pick_amt = bus.amount[32*j +: 32];
            end
        end
    end

    // Store lookup for the latched account (and its daily total when enabled).
    always_comb begin
        acc_ok = int'(acc_q) < NUM_ACC;
        rd_bal = '0;
        for (int i = 0; i < NUM_ACC; i++) begin
            if (int'(acc_q) == i) rd_bal = store_q[i];
        end
`ifdef ATM_DAILY_LIMIT_EN
        rd_today = '0;
        for (int i = 0; i < NUM_ACC; i++) begin
            if (int'(acc_q) == i) rd_today = today_q[i];
        end
        limit_ok = ({1'b0, rd_today} + {1'b0, amt_q}) <= 33'(DAILY_LIMIT);
`else
        limit_ok = 1'b1;
`endif
    end

    // Transaction sequencer: next-state and next-output computation.
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        win_d         = win_q;
        op_d          = op_q;
        acc_d         = acc_q;
        amt_d         = amt_q;
        bal_d         = bal_q;
        new_d         = new_q;
        succ_d        = succ_q;
        gnt_d         = gnt_q;
        done_d        = '0;
        rsp_success_d = rsp_success_q;
        rsp_balance_d = rsp_balance_q;
        store_d       = store_q;
        sum33         = {1'b0, bal_q} + {1'b0, amt_q};
`ifdef ATM_DAILY_LIMIT_EN
        today_d = today_q;
        // Clear lands before any in-flight withdraw is added below.
        if (day_clear) begin
            for (int i = 0; i < NUM_ACC; i++) today_d[i] = '0;
        end
`endif
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    win_d           = pick_idx;
                    op_d            = pick_op;
                    acc_d           = pick_acc;
                    amt_d           = pick_amt;
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                    state_d         = S_READ;
                end
            end
            S_READ: begin
                if (!acc_ok) begin
                    // Bad account: report failure with a zero balance, no write.
                    bal_d         = '0;
                    new_d         = '0;
                    succ_d        = 1'b0;
                    done_d[win_q] = 1'b1;
                    rsp_success_d = 1'b0;
                    rsp_balance_d = '0;
                    state_d       = S_DONE;
                end else begin
                    bal_d   = rd_bal;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                succ_d = 1'b0;
                new_d  = bal_q;
                case (op_q)
                    OP_BAL: succ_d = 1'b1;
                    OP_WD: begin
                        if (amt_q != '0 && amt_q <= bal_q && limit_ok) begin
                            succ_d = 1'b1;
                            new_d  = bal_q - amt_q;
                        end
                    end
                    OP_DEP: begin
                        if (amt_q != '0 && !sum33[32]) begin
                            succ_d = 1'b1;
                            new_d  = sum33[31:0];
                        end
                    end
                    default: succ_d = 1'b0;
                endcase
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (succ_q && (op_q == OP_WD || op_q == OP_DEP)) begin
                    for (int i = 0; i < NUM_ACC; i++) begin
                        if (int'(acc_q) == i) store_d[i] = new_q;
                    end
                end
`ifdef ATM_DAILY_LIMIT_EN
                if (succ_q && op_q == OP_WD) begin
                    for (int i = 0; i < NUM_ACC; i++) begin
                        if (int'(acc_q) == i) today_d[i] = today_d[i] + amt_q;
                    end
                end
`endif
                done_d[win_q] = 1'b1;
                rsp_success_d = succ_q;
                rsp_balance_d = new_q;
                state_d       = S_DONE;
            end
            S_DONE: begin
                rr_ptr_d = win_q;
                gnt_d    = '0;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // Register all state and outputs; synchronous reset reloads the store.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            rr_ptr_q      <= IDX_W'(N_TERM - 1);
            win_q         <= '0;
            op_q          <= '0;
            acc_q         <= '0;
            amt_q         <= '0;
            bal_q         <= '0;
            new_q         <= '0;
            succ_q        <= 1'b0;
            gnt_q         <= '0;
            done_q        <= '0;
            rsp_success_q <= 1'b0;
            rsp_balance_q <= '0;
            busy_q        <= 1'b0;
            for (int i = 0; i < NUM_ACC; i++) store_q[i] <= 32'((i + 1) * 1000);
`ifdef ATM_DAILY_LIMIT_EN
            for (int i = 0; i < NUM_ACC; i++) today_q[i] <= '0;
`endif
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            win_q         <= win_d;
            op_q          <= op_d;
            acc_q         <= acc_d;
            amt_q         <= amt_d;
            bal_q         <= bal_d;
            new_q         <= new_d;
            succ_q        <= succ_d;
            gnt_q         <= gnt_d;
            done_q        <= done_d;
            rsp_success_q <= rsp_success_d;
            rsp_balance_q <= rsp_balance_d;
            busy_q        <= busy_d;
            store_q       <= store_d;
`ifdef ATM_DAILY_LIMIT_EN
            today_q       <= today_d;
`endif
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.done        = done_q;
    assign bus.rsp_success = rsp_success_q;
    assign bus.rsp_balance = rsp_balance_q;
    assign bus.busy        = busy_q;
endmodule
